// File: rtl/oc8051_muldiv_seq_pkg.sv
// Shared encodings for the sequential MUL/DIV engine: operation codes and FSM states.
package oc8051_muldiv_seq_pkg;

    localparam logic [1:0] OC8051_MD_MULU = 2'b00;
    localparam logic [1:0] OC8051_MD_MULS = 2'b01;
    localparam logic [1:0] OC8051_MD_DIVU = 2'b10;
    localparam logic [1:0] OC8051_MD_DIVS = 2'b11;

    typedef enum logic [1:0] {
        OC8051_MD_IDLE = 2'b00,
        OC8051_MD_CALC = 2'b01,
        OC8051_MD_FIX  = 2'b10,
        OC8051_MD_FIN  = 2'b11
    } md_state_e;

endpackage

// File: rtl/oc8051_muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module oc8051_muldiv_step
    import oc8051_muldiv_seq_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  i_div,
    input  logic [2*DATA_W-1:0]   i_acc,
    input  logic [DATA_W-1:0]     i_opd,
    output logic [2*DATA_W-1:0]   o_acc
);

    logic [DATA_W-1:0] w_hi;
    logic [DATA_W-1:0] w_lo;
    logic [DATA_W-1:0] w_addend;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_shl;
    logic [DATA_W:0]   w_diff;

    always_comb begin
        w_hi     = i_acc[2*DATA_W-1:DATA_W];
        w_lo     = i_acc[DATA_W-1:0];
        w_addend = w_lo[0] ? i_opd : {DATA_W{1'b0}};
        w_sum    = {1'b0, w_hi} + {1'b0, w_addend};
        // Partial remainder is shifted left by one before the trial subtract.
        w_shl    = {w_hi, w_lo[DATA_W-1]};
        w_diff   = w_shl - {1'b0, i_opd};
        o_acc    = {w_sum, w_lo[DATA_W-1:1]};
        if (i_div) begin
            if (!w_diff[DATA_W]) begin
                o_acc = {w_diff[DATA_W-1:0], w_lo[DATA_W-2:0], 1'b1};
            end else begin
                o_acc = {w_shl[DATA_W-1:0], w_lo[DATA_W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/oc8051_muldiv_seq.sv
// Multi-cycle MUL/DIV engine: FSM, iteration counter, sign bookkeeping and result registers.
module oc8051_muldiv_seq
    import oc8051_muldiv_seq_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit SIGNED_EN = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] des1,
    output logic [DATA_W-1:0] des2,
    output logic              desOv
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    function automatic logic [DATA_W-1:0] cond_neg(input logic neg, input logic [DATA_W-1:0] x);
        return neg ? -x : x;
    endfunction

    function automatic logic [2*DATA_W-1:0] cond_neg2(input logic neg, input logic [2*DATA_W-1:0] x);
        return neg ? -x : x;
    endfunction

    md_state_e           r_state;
    md_state_e           w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_div;
    logic                r_sgn;
    logic                r_neg_res;
    logic                r_neg_dvd;
    logic                r_dz;
    logic [DATA_W-1:0]   r_opd;
    logic [2*DATA_W-1:0] r_acc;
    logic                r_busy;
    logic                r_done;
    logic [DATA_W-1:0]   r_des1;
    logic [DATA_W-1:0]   r_des2;
    logic                r_ov;

    logic                w_div;
    logic                w_sgn;
    logic                w_s1;
    logic                w_s2;
    logic                w_dz;
    logic [DATA_W-1:0]   w_mag1;
    logic [DATA_W-1:0]   w_mag2;
    logic [2*DATA_W-1:0] w_acc_step;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_fix1;
    logic [DATA_W-1:0]   w_fix2;
    logic                w_fix_ov;

    // Request decode; op[0] only matters when signed support is built in.
    always_comb begin
        w_div  = (op == OC8051_MD_DIVU) || (op == OC8051_MD_DIVS);
        w_sgn  = SIGNED_EN && ((op == OC8051_MD_MULS) || (op == OC8051_MD_DIVS));
        w_s1   = w_sgn && src1[DATA_W-1];
        w_s2   = w_sgn && src2[DATA_W-1];
        w_dz   = w_div && (src2 == {DATA_W{1'b0}});
        w_mag1 = cond_neg(w_s1, src1);
        w_mag2 = cond_neg(w_s2, src2);
    end

    oc8051_muldiv_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .i_div (r_div),
        .i_acc (r_acc),
        .i_opd (r_opd),
        .o_acc (w_acc_step)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            OC8051_MD_IDLE: if (start) w_state_nxt = w_dz ? OC8051_MD_FIX : OC8051_MD_CALC;
            OC8051_MD_CALC: if (r_cnt == CNT_LAST) w_state_nxt = OC8051_MD_FIX;
            OC8051_MD_FIX:  w_state_nxt = OC8051_MD_FIN;
            OC8051_MD_FIN:  w_state_nxt = OC8051_MD_IDLE;
            default:        w_state_nxt = OC8051_MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= OC8051_MD_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == OC8051_MD_CALC) || (w_state_nxt == OC8051_MD_FIX);
            r_done  <= (w_state_nxt == OC8051_MD_FIN);
        end
    end

    // Sign correction of the unsigned magnitude result and overflow detection.
    always_comb begin
        w_prod   = cond_neg2(r_neg_res, r_acc);
        w_fix1   = w_prod[DATA_W-1:0];
        w_fix2   = w_prod[2*DATA_W-1:DATA_W];
        w_fix_ov = r_sgn ? (w_fix2 != {DATA_W{w_fix1[DATA_W-1]}})
                         : (w_fix2 != {DATA_W{1'b0}});
        if (r_div) begin
            if (r_dz) begin
                w_fix1   = {DATA_W{1'b1}};
                w_fix2   = r_acc[DATA_W-1:0];
                w_fix_ov = 1'b1;
            end else begin
                w_fix1   = cond_neg(r_neg_res, r_acc[DATA_W-1:0]);
                w_fix2   = cond_neg(r_neg_dvd, r_acc[2*DATA_W-1:DATA_W]);
                // Only most-negative / -1 yields a positive quotient with the MSB set.
                w_fix_ov = r_sgn && !r_neg_res && r_acc[DATA_W-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_div     <= 1'b0;
            r_sgn     <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_dvd <= 1'b0;
            r_dz      <= 1'b0;
            r_opd     <= '0;
            r_acc     <= '0;
            r_des1    <= '0;
            r_des2    <= '0;
            r_ov      <= 1'b0;
        end else begin
            case (r_state)
                OC8051_MD_IDLE: begin
                    if (start) begin
                        r_div     <= w_div;
                        r_sgn     <= w_sgn;
                        r_neg_res <= w_s1 ^ w_s2;
                        r_neg_dvd <= w_s1;
                        r_dz      <= w_dz;
                        r_opd     <= w_mag2;
                        r_acc     <= {{DATA_W{1'b0}}, (w_dz ? src1 : w_mag1)};
                        r_cnt     <= '0;
                    end
                end
                OC8051_MD_CALC: begin
                    r_acc <= w_acc_step;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                OC8051_MD_FIX: begin
                    r_des1 <= w_fix1;
                    r_des2 <= w_fix2;
                    r_ov   <= w_fix_ov;
                end
                default: ;
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign des1  = r_des1;
    assign des2  = r_des2;
    assign desOv = r_ov;

endmodule

// File: doc/oc8051_muldiv_seq.md
Name: oc8051_muldiv_seq

Overview:
- Parametrised, multi-cycle, radix-2 multiply/divide engine; the next generation of the ALU's MUL/DIV path.
- Unsigned and optional signed modes, any even data width, explicit start/busy/done handshake.
- Sits beside the ALU. The decoder issues start; the ALU reads des1 (ACC-side) and des2 (B-side) when done pulses.
- The OV flag follows 8051 MUL AB / DIV AB rules, generalised to DATA_W.

Parameters:
- DATA_W, 8: operand/result width; even, >=4.
- SIGNED_EN, 0: 1 enables signed ops. With 0, op[0] is ignored and every op runs unsigned.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only in IDLE.
- op  in  2  00 MULU, 01 MULS, 10 DIVU, 11 DIVS; sampled with start.
- src1  in  DATA_W  multiplicand / dividend; sampled with start.
- src2  in  DATA_W  multiplier / divisor; sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  single-cycle pulse; results valid from this cycle.
- des1  out  DATA_W  product low half / quotient.
- des2  out  DATA_W  product high half / remainder.
- desOv  out  1  overflow / divide error.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; busy=0, done=0, des1=0, des2=0, desOv=0; all internal registers 0.
- Reset mid-operation: aborts the operation; no done pulse is produced.
- States: IDLE -> CALC -> FIX -> FIN -> IDLE.
- IDLE:
  - start=1 latches op, src1, src2.
  - Signed ops: latches magnitudes plus the sign of the result and the sign of the dividend.
  - Next state is CALC, or FIX directly for any DIV with src2==0.
- CALC: exactly DATA_W cycles; an iteration counter runs 0..DATA_W-1.
  - MUL: shift-add, 2*DATA_W accumulator.
  - DIV: restoring shift-subtract.
- FIX: one cycle. Applies two's-complement correction for signed ops and computes desOv.
- FIN: done=1 for this cycle only; des1/des2/desOv update in this cycle. Next state is IDLE.
- Latency: accepted start at cycle 0 gives done at cycle DATA_W+2. Divide-by-zero gives done at cycle 2.
- busy: 1 in CALC and FIX, 0 in FIN and IDLE.
- start while busy: ignored, with no queuing. start in the FIN cycle is also ignored.
- Output hold: des1/des2/desOv hold their last values until the next FIN or rst.
- MULU: {des2,des1} = src1*src2. desOv=1 iff des2 != 0.
- MULS: signed 2*DATA_W product. desOv=1 iff des2 is not the sign extension of des1[DATA_W-1].
- DIVU: des1 = src1/src2, des2 = src1%src2, desOv=0.
- DIVS: quotient truncated toward zero; remainder takes the dividend's sign; desOv=0.
- DIVS special case, most-negative / -1: des1 = src1, des2 = 0, desOv=1.
- Divide by zero (DIVU or DIVS): des1 = all ones, des2 = src1, desOv=1.
- Zero operands are otherwise not special-cased for MUL; they run the full latency.
- No combinational path from start/src to any output; all outputs are registered.

Decomposition:
- Shared defines file (oc8051_defines.v style) holds:
  - op encodings OC8051_MD_MULU / MULS / DIVU / DIVS;
  - state encodings OC8051_MD_IDLE / CALC / FIX / FIN.
- One natural sub-module: oc8051_muldiv_step.
  - Combinational single-iteration datapath (add-or-pass for MUL, trial-subtract for DIV), parametrised by DATA_W.
  - The top holds the FSM, counter, sign bookkeeping and output registers.

Test Plan (DATA_W=8 unless noted):
- MULU 0x0C*0x15 -> des1=0xFC, des2=0x00, desOv=0; done exactly at cycle 10, busy high cycles 1-9.
- MULU 0xFF*0xFF -> des1=0x01, des2=0xFE, desOv=1. MULS 0xFE*0x03 (SIGNED_EN=1) -> des1=0xFA, des2=0xFF, desOv=0.
- DIVU 0xFB/0x12 -> des1=0x0D, des2=0x11, desOv=0. Then DIVU 0x55/0x00 -> done at cycle 2, des1=0xFF, des2=0x55, desOv=1.
- DIVS 0xF9/0x02 -> des1=0xFD, des2=0xFF, desOv=0. DIVS 0x80/0xFF -> des1=0x80, des2=0x00, desOv=1.
- Back-to-back and abort:
  - start held high continuously -> a new operation begins only in the cycle after FIN.
  - rst at cycle 4 of a MUL -> busy=0, done stays 0, outputs 0.
- DATA_W=16, SIGNED_EN=0: MULU 0xFFFF*0x0002 -> des1=0xFFFE, des2=0x0001, desOv=1, done at cycle 18. MULS request runs as MULU.
